// File: rtl/vector_sequencer.sv
// Vector command sequencer feeding the X/Y poscounter pair: absolute loads, timed relative draws, halt.
// Optional beam-settle wait after an absolute load is enabled by defining VSEQ_SETTLE_EN.
module vector_sequencer #(
    parameter int TICK_DIV      = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    input  logic        restart,
    output logic [11:0] dvx,
    output logic [11:0] dvy,
    output logic        go,
    output logic        haltstrobe,
    output logic        timer0,
    output logic        busy,
    output logic        halted
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
`ifdef VSEQ_SETTLE_EN
        ST_SETTLE = 3'd2,
`endif
        ST_DRAW   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] OP_DRAW   = 2'b00;
    localparam logic [1:0] OP_CENTER = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [7:0] DIV_RELOAD = 8'(TICK_DIV - 1);

    // Empty marker scope appears in the elaborated hierarchy when a parameter is out of range.
    if (TICK_DIV < 1 || TICK_DIV > 255 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_param_out_of_range
    end

    state_t      state_q, state_d;
    logic [11:0] dvx_q, dvx_d;
    logic [11:0] dvy_q, dvy_d;
    logic [7:0]  div_q, div_d;
    logic [6:0]  step_q, step_d;
    logic        go_q, go_d;
    logic        haltstrobe_q, haltstrobe_d;
    logic        timer0_q, timer0_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
`ifdef VSEQ_SETTLE_EN
    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
    logic [7:0]  settle_q, settle_d;
`endif

    always_comb begin
        state_d = state_q;
        dvx_d   = dvx_q;
        dvy_d   = dvy_q;
        div_d   = div_q;
        step_d  = step_q;
`ifdef VSEQ_SETTLE_EN
        settle_d = settle_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_data[31:30])
                        OP_DRAW: begin
                            dvx_d   = cmd_data[29:18];
                            dvy_d   = cmd_data[17:6];
                            step_d  = {1'b0, cmd_data[5:0]} + 7'd1;
                            div_d   = DIV_RELOAD;
                            state_d = ST_DRAW;
                        end
                        OP_CENTER: begin
                            dvx_d   = cmd_data[29:18];
                            dvy_d   = cmd_data[17:6];
                            state_d = ST_LOAD;
                        end
                        OP_HALT: state_d = ST_HALTED;
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
`ifdef VSEQ_SETTLE_EN
                settle_d = SETTLE_RELOAD;
                state_d  = ST_SETTLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef VSEQ_SETTLE_EN
            ST_SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
`endif
            ST_DRAW: begin
                // A divider value of zero is the tick cycle; the final tick also ends the draw.
                if (div_q == 8'd0) begin
                    step_d = step_q - 7'd1;
                    div_d  = DIV_RELOAD;
                    if (step_d == 7'd0) begin
                        div_d   = 8'd0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            ST_HALTED: begin
                if (restart) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered from the next state so they align with the cycle they describe.
        go_d         = (state_d == ST_DRAW);
        timer0_d     = (state_d == ST_DRAW) && (div_d == 8'd0);
        haltstrobe_d = (state_d == ST_LOAD);
        busy_d       = (state_d != ST_IDLE);
        halted_d     = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dvx_q        <= 12'd0;
            dvy_q        <= 12'd0;
            div_q        <= 8'd0;
            step_q       <= 7'd0;
            go_q         <= 1'b0;
            haltstrobe_q <= 1'b0;
            timer0_q     <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
`ifdef VSEQ_SETTLE_EN
            settle_q     <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            dvx_q        <= dvx_d;
            dvy_q        <= dvy_d;
            div_q        <= div_d;
            step_q       <= step_d;
            go_q         <= go_d;
            haltstrobe_q <= haltstrobe_d;
            timer0_q     <= timer0_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
`ifdef VSEQ_SETTLE_EN
            settle_q     <= settle_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign dvx        = dvx_q;
    assign dvy        = dvy_q;
    assign go         = go_q;
    assign haltstrobe = haltstrobe_q;
    assign timer0     = timer0_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: two instances (TICK_DIV 4 and 1) checked against cycle timing
// predicted from command arithmetic; directed plan cases followed by random command traffic.
module tb_vector_sequencer;
    localparam int SETTLE_N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid_s  [2];
    logic [31:0] cmd_data_s   [2];
    logic        restart_s    [2];
    logic        cmd_ready_s  [2];
    logic [11:0] dvx_s        [2];
    logic [11:0] dvy_s        [2];
    logic        go_s         [2];
    logic        haltstrobe_s [2];
    logic        timer0_s     [2];
    logic        busy_s       [2];
    logic        halted_s     [2];

    // Reference state: last latched vector per instance and its tick divide ratio.
    logic [11:0] dvx_m [2];
    logic [11:0] dvy_m [2];
    int          td_m  [2];

    int total_cnt = 0;
    int bad_cnt   = 0;
    int txn_cnt   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        vector_sequencer #(
            .TICK_DIV      ((gi == 0) ? 4 : 1),
            .SETTLE_CYCLES (SETTLE_N)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .cmd_valid  (cmd_valid_s[gi]),
            .cmd_ready  (cmd_ready_s[gi]),
            .cmd_data   (cmd_data_s[gi]),
            .restart    (restart_s[gi]),
            .dvx        (dvx_s[gi]),
            .dvy        (dvy_s[gi]),
            .go         (go_s[gi]),
            .haltstrobe (haltstrobe_s[gi]),
            .timer0     (timer0_s[gi]),
            .busy       (busy_s[gi]),
            .halted     (halted_s[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int sel, input string tag);
        check({tag, "_ready"},  32'(cmd_ready_s[sel]), 32'd1);
        check({tag, "_busy"},   32'(busy_s[sel]), 32'd0);
        check({tag, "_go"},     32'(go_s[sel]), 32'd0);
        check({tag, "_timer0"}, 32'(timer0_s[sel]), 32'd0);
        check({tag, "_hstb"},   32'(haltstrobe_s[sel]), 32'd0);
        check({tag, "_halted"}, 32'(halted_s[sel]), 32'd0);
        check({tag, "_dvx"},    32'(dvx_s[sel]), 32'(dvx_m[sel]));
        check({tag, "_dvy"},    32'(dvy_s[sel]), 32'(dvy_m[sel]));
    endtask

    task automatic do_draw(input int sel, input logic [11:0] x, input logic [11:0] y, input int len);
        int total;
        int ticks;
        total = (len + 1) * td_m[sel];
        ticks = 0;
        cmd_data_s[sel]  = {2'b00, x, y, 6'(len)};
        cmd_valid_s[sel] = 1'b1;
        check("draw_accept_ready", 32'(cmd_ready_s[sel]), 32'd1);
        tick();
        cmd_valid_s[sel] = 1'b0;
        dvx_m[sel] = x;
        dvy_m[sel] = y;
        for (int c = 1; c <= total; c++) begin
            check("draw_go",     32'(go_s[sel]), 32'd1);
            check("draw_timer0", 32'(timer0_s[sel]), 32'((c % td_m[sel]) == 0));
            check("draw_hstb",   32'(haltstrobe_s[sel]), 32'd0);
            check("draw_ready",  32'(cmd_ready_s[sel]), 32'd0);
            check("draw_busy",   32'(busy_s[sel]), 32'd1);
            check("draw_dvx",    32'(dvx_s[sel]), 32'(x));
            if (timer0_s[sel] === 1'b1) ticks++;
            tick();
        end
        check("draw_tick_count", 32'(ticks), 32'(len + 1));
        check_idle(sel, "draw_end");
        txn_cnt++;
        $display("txn %0d: inst=%0d DRAW x=%03h y=%03h len=%0d go_cycles=%0d ticks=%0d",
                 txn_cnt, sel, x, y, len, total, ticks);
    endtask

    task automatic do_center(input int sel, input logic [11:0] x, input logic [11:0] y);
        int wait_cycles;
`ifdef VSEQ_SETTLE_EN
        wait_cycles = SETTLE_N;
`else
        wait_cycles = 0;
`endif
        cmd_data_s[sel]  = {2'b01, x, y, 6'($urandom_range(0, 63))};
        cmd_valid_s[sel] = 1'b1;
        check("center_accept_ready", 32'(cmd_ready_s[sel]), 32'd1);
        tick();
        cmd_valid_s[sel] = 1'b0;
        dvx_m[sel] = x;
        dvy_m[sel] = y;
        check("center_hstb",  32'(haltstrobe_s[sel]), 32'd1);
        check("center_go",    32'(go_s[sel]), 32'd0);
        check("center_ready", 32'(cmd_ready_s[sel]), 32'd0);
        check("center_busy",  32'(busy_s[sel]), 32'd1);
        check("center_dvx",   32'(dvx_s[sel]), 32'(x));
        check("center_dvy",   32'(dvy_s[sel]), 32'(y));
        tick();
        for (int c = 0; c < wait_cycles; c++) begin
            check("settle_busy",  32'(busy_s[sel]), 32'd1);
            check("settle_ready", 32'(cmd_ready_s[sel]), 32'd0);
            check("settle_hstb",  32'(haltstrobe_s[sel]), 32'd0);
            check("settle_go",    32'(go_s[sel]), 32'd0);
            tick();
        end
        check_idle(sel, "center_end");
        txn_cnt++;
        $display("txn %0d: inst=%0d CENTER x=%03h y=%03h ready_after=%0d",
                 txn_cnt, sel, x, y, 2 + wait_cycles);
    endtask

    task automatic do_nop(input int sel, input int n);
        cmd_valid_s[sel] = 1'b1;
        for (int i = 0; i < n; i++) begin
            cmd_data_s[sel] = {2'b11, 30'($urandom)};
            check("nop_ready", 32'(cmd_ready_s[sel]), 32'd1);
            tick();
            check_idle(sel, "nop");
        end
        cmd_valid_s[sel] = 1'b0;
        txn_cnt++;
        $display("txn %0d: inst=%0d NOP x%0d", txn_cnt, sel, n);
    endtask

    task automatic do_halt(input int sel, input int hold);
        cmd_data_s[sel]  = {2'b10, 30'($urandom)};
        cmd_valid_s[sel] = 1'b1;
        check("halt_accept_ready", 32'(cmd_ready_s[sel]), 32'd1);
        tick();
        // Commands offered while halted must be refused.
        for (int i = 0; i < hold; i++) begin
            cmd_data_s[sel] = {2'b00, 30'($urandom)};
            check("halted_flag",  32'(halted_s[sel]), 32'd1);
            check("halted_ready", 32'(cmd_ready_s[sel]), 32'd0);
            check("halted_busy",  32'(busy_s[sel]), 32'd1);
            check("halted_go",    32'(go_s[sel]), 32'd0);
            check("halted_dvx",   32'(dvx_s[sel]), 32'(dvx_m[sel]));
            tick();
        end
        cmd_valid_s[sel] = 1'b0;
        check("halted_hold", 32'(halted_s[sel]), 32'd1);
        restart_s[sel] = 1'b1;
        tick();
        restart_s[sel] = 1'b0;
        check_idle(sel, "restart");
        restart_s[sel] = 1'b1;
        tick();
        restart_s[sel] = 1'b0;
        check_idle(sel, "restart_idle");
        txn_cnt++;
        $display("txn %0d: inst=%0d HALT hold=%0d then restart", txn_cnt, sel, hold);
    endtask

    task automatic do_reset_mid_draw(input int sel, input int run);
        cmd_data_s[sel]  = {2'b00, 12'h4C8, 12'h123, 6'd10};
        cmd_valid_s[sel] = 1'b1;
        check("rdraw_accept_ready", 32'(cmd_ready_s[sel]), 32'd1);
        tick();
        cmd_valid_s[sel] = 1'b0;
        for (int i = 0; i < run; i++) tick();
        check("rdraw_go_before", 32'(go_s[sel]), 32'd1);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            dvx_m[i] = 12'd0;
            dvy_m[i] = 12'd0;
        end
        check("rst_go",     32'(go_s[sel]), 32'd0);
        check("rst_timer0", 32'(timer0_s[sel]), 32'd0);
        check("rst_dvx",    32'(dvx_s[sel]), 32'd0);
        check("rst_busy",   32'(busy_s[sel]), 32'd0);
        reset = 1'b0;
        check("rst_ready", 32'(cmd_ready_s[sel]), 32'd1);
        tick();
        check_idle(sel, "rst_after");
        txn_cnt++;
        $display("txn %0d: inst=%0d reset after %0d draw cycles", txn_cnt, sel, run + 1);
    endtask

    initial begin
        td_m[0] = 4;
        td_m[1] = 1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid_s[i] = 1'b0;
            cmd_data_s[i]  = 32'd0;
            restart_s[i]   = 1'b0;
            dvx_m[i]       = 12'd0;
            dvy_m[i]       = 12'd0;
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) check_idle(i, "reset");

        do_center(0, 12'd514, 12'd0);
        do_draw(0, 12'h4C8, 12'h010, 2);
        do_draw(1, 12'h7FF, 12'h400, 0);
        do_nop(1, 3);
        do_halt(0, 5);
        do_reset_mid_draw(0, 5);
        do_draw(0, 12'h001, 12'hFFF, 0);

        for (int t = 0; t < 40; t++) begin
            int sel;
            int op;
            sel = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 3));
            case (op)
                0: do_draw(sel, 12'($urandom), 12'($urandom), int'($urandom_range(0, 7)));
                1: do_center(sel, 12'($urandom), 12'($urandom));
                2: do_halt(sel, int'($urandom_range(1, 5)));
                default: do_nop(sel, int'($urandom_range(1, 3)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Command-driven control stage directly upstream of `poscounter`. Accepts vector commands over a valid/ready interface and drives `dv`, `go`, `haltstrobe` and `timer0` for the X and Y position counters. It sequences absolute beam positioning and timed relative draws, and reports halt status to the display-list fetcher.

## Interface
- `TICK_DIV`, 4: clocks per `timer0` pulse during a draw; legal range 1..255.
- `SETTLE_CYCLES`, 8: beam-settle wait after an absolute load; used only when `VSEQ_SETTLE_EN` is defined; legal range 1..255.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command word present.
- `cmd_ready`  out  1  sequencer accepts a command this cycle.
- `cmd_data`  in  32  command word:
  - [31:30] opcode: 00 DRAW, 01 CENTER, 10 HALT, 11 NOP.
  - [29:18] X value.
  - [17:6] Y value.
  - [5:0] `len`.
- `restart`  in  1  leave the HALTED state.
- `dvx`  out  12  to X `poscounter.dv`.
- `dvy`  out  12  to Y `poscounter.dv`.
- `go`  out  1  draw enable, shared by both counters.
- `haltstrobe`  out  1  one-cycle absolute-position load, shared.
- `timer0`  out  1  one-cycle step tick, shared.
- `busy`  out  1  state is not IDLE.
- `halted`  out  1  state is HALTED.

## Operation
- States: IDLE, LOAD, SETTLE (only when the macro is defined), DRAW, HALTED.
- `cmd_ready` = (state == IDLE). A command is accepted when `cmd_valid && cmd_ready`.
- Accept DRAW:
  - Latch `dvx`/`dvy` from [29:18]/[17:6].
  - Load the step counter with `len`+1 and the tick divider with `TICK_DIV`-1.
  - Go to DRAW.
- DRAW:
  - `go`=1 throughout.
  - Divider decrements each cycle. When it is 0, `timer0`=1 for that cycle, the divider reloads `TICK_DIV`-1, and the step counter decrements.
  - The cycle in which the step counter reaches 0 with `timer0`=1 is the last DRAW cycle. Next state is IDLE.
- Accept CENTER: latch `dvx`/`dvy`, go to LOAD.
- LOAD: `haltstrobe`=1 for exactly one cycle, `go`=0. Next state is SETTLE if the macro is defined, otherwise IDLE.
- Accept HALT: go to HALTED.
- HALTED: `halted`=1, `cmd_ready`=0. `restart`=1 moves to IDLE on the next edge. `restart` in any other state is ignored.
- Accept NOP: command consumed, no state change, no output change.
- `dvx`/`dvy` are 12-bit pass-through with no sign or magnitude interpretation. Bit 10 is the `poscounter` direction bit. Values hold until the next DRAW or CENTER.
- `timer0` and `haltstrobe` are never asserted outside DRAW and LOAD respectively.
- `go` and `haltstrobe` are never high in the same cycle.
- Reset:
  - State becomes IDLE.
  - `dvx`, `dvy`, `go`, `haltstrobe`, `timer0`, `busy` and `halted` all become 0.
  - Divider and step counter clear.
  - Reset wins over `restart` and command acceptance. Reset mid-DRAW drops `go` and `timer0` at that edge.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state.
- DRAW accepted in cycle N:
  - `go`=1 in cycles N+1 .. N+(`len`+1)·`TICK_DIV`.
  - `timer0` pulses at N+k·`TICK_DIV`, k = 1..`len`+1.
  - `cmd_ready`=1 again at N+(`len`+1)·`TICK_DIV`+1.
- `len`=0 gives one tick. With `TICK_DIV`=1, `timer0` is high every DRAW cycle.
- CENTER accepted in cycle N: `haltstrobe`=1 in cycle N+1, `cmd_ready`=1 in cycle N+2 (settle disabled).
- HALT accepted in cycle N: `halted`=1 from N+1. `restart` seen in cycle M gives `cmd_ready`=1 at M+1.
- Back-to-back throughput: one command per IDLE cycle. There is no skid buffering.

## Configuration
- `VSEQ_SETTLE_EN` defined:
  - LOAD is followed by SETTLE.
  - A counter waits `SETTLE_CYCLES` cycles with `busy`=1, `cmd_ready`=0, `go`=0, then goes to IDLE.
  - CENTER accepted in cycle N gives `cmd_ready`=1 at N+2+`SETTLE_CYCLES`.
- Not defined: the SETTLE state and counter are absent. LOAD goes directly to IDLE.

## Test plan
- Reset, then CENTER X=514, Y=0 -> `haltstrobe` high exactly 1 cycle, `dvx`=514, `go`=0, `cmd_ready` back 2 cycles after acceptance (macro off).
- `TICK_DIV`=4, DRAW X=0x4C8 (dir=1, mag 200), `len`=2 -> `go` high 12 cycles, `timer0` at +4/+8/+12, `dvx`=0x4C8 stable, then IDLE.
- `TICK_DIV`=1, DRAW `len`=0 -> `go` and `timer0` both high for exactly 1 cycle; NOP with `cmd_valid` held -> consumed, no outputs move.
- HALT, then assert `cmd_valid` for 5 cycles -> `cmd_ready`=0 and `halted`=1; pulse `restart` -> `cmd_ready`=1 next cycle; `restart` while IDLE -> no effect.
- Reset asserted mid-DRAW (`len`=10) -> next edge: `go`=0, `timer0`=0, `dvx`=0, `busy`=0, `cmd_ready`=1 after reset releases.
- `VSEQ_SETTLE_EN` with `SETTLE_CYCLES`=8: CENTER -> `cmd_ready` returns 10 cycles after acceptance, `busy` high throughout.
